pipe_skid_reg: RTL and testbench

Parametrised inter-stage pipeline register for the processor datapath, replacing the fixed-width decode/execute latch. It carries NUM_OPS operand words, a destination-register tag and a control vector from one stage to the next. It adds a valid/ready handshake with a two-entry skid buffer, so back-pressure never creates a combinational ready path. It also supports a synchronous flush for branch or hazard squashing, and forces control outputs to zero whenever no valid instruction is held.

---
 rtl/pipe_pkg.sv | 21 ++
 rtl/pipe_payload_reg.sv | 46 ++++
 rtl/pipe_skid_reg.sv | 139 +++++++++++++
 tb/tb_pipe_skid_reg.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_pkg
// Brief    : Shared state encoding and default widths for the skid pipeline reg.
// Revision : 1.0
// ============================================================================
package pipe_pkg;

    localparam int DATA_W_DEF  = 32;
    localparam int REG_W_DEF   = 4;
    localparam int CTRL_W_DEF  = 9;
    localparam int NUM_OPS_DEF = 4;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

endpackage : pipe_pkg
`default_nettype wire

// File: rtl/pipe_payload_reg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_payload_reg
// Brief    : Load-enabled, reset-to-zero register bank for {ops, rd, ctrl}.
// Revision : 1.0
// ============================================================================
module pipe_payload_reg
    import pipe_pkg::*;
#(
    parameter int OPS_W  = NUM_OPS_DEF * DATA_W_DEF,
    parameter int REG_W  = REG_W_DEF,
    parameter int CTRL_W = CTRL_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [OPS_W-1:0]  d_ops,
    input  logic [REG_W-1:0]  d_rd,
    input  logic [CTRL_W-1:0] d_ctrl,
    output logic [OPS_W-1:0]  q_ops,
    output logic [REG_W-1:0]  q_rd,
    output logic [CTRL_W-1:0] q_ctrl
);

    logic [OPS_W-1:0]  r_ops;
    logic [REG_W-1:0]  r_rd;
    logic [CTRL_W-1:0] r_ctrl;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ops  <= '0;
            r_rd   <= '0;
            r_ctrl <= '0;
        end else if (load) begin
            r_ops  <= d_ops;
            r_rd   <= d_rd;
            r_ctrl <= d_ctrl;
        end
    end

    assign q_ops  = r_ops;
    assign q_rd   = r_rd;
    assign q_ctrl = r_ctrl;

endmodule : pipe_payload_reg
`default_nettype wire

// File: rtl/pipe_skid_reg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_skid_reg
// Brief    : Inter-stage pipeline register with valid/ready, 2-entry skid, flush.
// Revision : 1.0
// ============================================================================
module pipe_skid_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int NUM_OPS = NUM_OPS_DEF,
    parameter int REG_W   = REG_W_DEF,
    parameter int CTRL_W  = CTRL_W_DEF
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [NUM_OPS*DATA_W-1:0] in_ops,
    input  logic [REG_W-1:0]          in_rd,
    input  logic [CTRL_W-1:0]         in_ctrl,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [NUM_OPS*DATA_W-1:0] out_ops,
    output logic [REG_W-1:0]          out_rd,
    output logic [CTRL_W-1:0]         out_ctrl,
    output logic [1:0]                occupancy
);

    localparam int OPS_W = NUM_OPS * DATA_W;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              w_accept;
    logic              w_consume;
    logic              w_main_load;
    logic              w_main_from_skid;
    logic              w_skid_load;

    logic [OPS_W-1:0]  w_main_ops,  w_skid_ops,  w_main_d_ops;
    logic [REG_W-1:0]  w_main_rd,   w_skid_rd,   w_main_d_rd;
    logic [CTRL_W-1:0] w_main_ctrl, w_skid_ctrl, w_main_d_ctrl;

    // Handshake flags come from registered state only, so no ready path exists.
    assign in_ready  = (r_state != FULL);
    assign out_valid = (r_state != EMPTY);
    assign occupancy = r_state;
    assign w_accept  = in_valid & in_ready;
    assign w_consume = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_main_load      = 1'b0;
        w_main_from_skid = 1'b0;
        w_skid_load      = 1'b0;
        if (flush) begin
            // Squash leaves payload as-is; the ctrl mask hides it downstream.
            w_state_nxt = EMPTY;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_accept) begin
                        w_main_load = 1'b1;
                        w_state_nxt = ONE;
                    end
                end
                ONE: begin
                    if (w_accept && w_consume) begin
                        w_main_load = 1'b1;
                    end else if (w_accept) begin
                        w_skid_load = 1'b1;
                        w_state_nxt = FULL;
                    end else if (w_consume) begin
                        w_state_nxt = EMPTY;
                    end
                end
                FULL: begin
                    if (w_consume) begin
                        w_main_load      = 1'b1;
                        w_main_from_skid = 1'b1;
                        w_state_nxt      = ONE;
                    end
                end
                default: w_state_nxt = EMPTY;
            endcase
        end
    end

    assign w_main_d_ops  = w_main_from_skid ? w_skid_ops  : in_ops;
    assign w_main_d_rd   = w_main_from_skid ? w_skid_rd   : in_rd;
    assign w_main_d_ctrl = w_main_from_skid ? w_skid_ctrl : in_ctrl;

    pipe_payload_reg #(
        .OPS_W  (OPS_W),
        .REG_W  (REG_W),
        .CTRL_W (CTRL_W)
    ) u_main (
        .clk    (clk),
        .reset  (reset),
        .load   (w_main_load),
        .d_ops  (w_main_d_ops),
        .d_rd   (w_main_d_rd),
        .d_ctrl (w_main_d_ctrl),
        .q_ops  (w_main_ops),
        .q_rd   (w_main_rd),
        .q_ctrl (w_main_ctrl)
    );

    pipe_payload_reg #(
        .OPS_W  (OPS_W),
        .REG_W  (REG_W),
        .CTRL_W (CTRL_W)
    ) u_skid (
        .clk    (clk),
        .reset  (reset),
        .load   (w_skid_load),
        .d_ops  (in_ops),
        .d_rd   (in_rd),
        .d_ctrl (in_ctrl),
        .q_ops  (w_skid_ops),
        .q_rd   (w_skid_rd),
        .q_ctrl (w_skid_ctrl)
    );

    assign out_ops  = w_main_ops;
    assign out_rd   = w_main_rd;
    assign out_ctrl = w_main_ctrl & {CTRL_W{out_valid}};

endmodule : pipe_skid_reg
`default_nettype wire

// File: tb/tb_pipe_skid_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_skid_reg
// Brief    : Queue-model bench for pipe_skid_reg, default build plus 2x16 build.
// Revision : 1.0
// ============================================================================
module tb_pipe_skid_reg;

    typedef struct packed {
        logic [127:0] ops;
        logic [3:0]   rd;
        logic [8:0]   ctrl;
    } ent_t;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         flush = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [127:0] in_ops = '0;
    logic [3:0]   in_rd = '0;
    logic [8:0]   in_ctrl = '0;
    logic [31:0]  in_ops2;

    logic         in_ready, out_valid, in_ready2, out_valid2;
    logic [127:0] out_ops;
    logic [31:0]  out_ops2;
    logic [3:0]   out_rd, out_rd2;
    logic [8:0]   out_ctrl, out_ctrl2;
    logic [1:0]   occupancy, occupancy2;

    int n_checks = 0;
    int n_fail   = 0;

    // Narrow build carries the low 16 bits of words 0 and 1.
    assign in_ops2 = {in_ops[47:32], in_ops[15:0]};

    always #5 clk = ~clk;

    pipe_skid_reg dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_ops(in_ops), .in_rd(in_rd), .in_ctrl(in_ctrl),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_ops(out_ops), .out_rd(out_rd), .out_ctrl(out_ctrl),
        .occupancy(occupancy)
    );

    pipe_skid_reg #(.DATA_W(16), .NUM_OPS(2)) dut2 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready2),
        .in_ops(in_ops2), .in_rd(in_rd), .in_ctrl(in_ctrl),
        .out_valid(out_valid2), .out_ready(out_ready),
        .out_ops(out_ops2), .out_rd(out_rd2), .out_ctrl(out_ctrl2),
        .occupancy(occupancy2)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: an ordered queue of held entries plus the last head seen.
    ent_t q[$];
    ent_t main_hold;
    bit   m_init = 0;

    always @(posedge clk) begin
        bit   acc, cons;
        ent_t e;
        if (reset) begin
            q.delete();
            main_hold = '0;
            m_init    = 1;
        end else if (m_init) begin
            if (flush) begin
                q.delete();
            end else begin
                acc  = in_valid && (q.size() < 2);
                cons = (q.size() > 0) && out_ready;
                if (cons) void'(q.pop_front());
                if (acc) begin
                    e.ops = in_ops; e.rd = in_rd; e.ctrl = in_ctrl;
                    q.push_back(e);
                end
            end
            if (q.size() > 0) main_hold = q[0];
        end
    end

    always @(negedge clk) begin
        logic       v;
        logic [1:0] occ;
        if (m_init) begin
            v   = (q.size() > 0);
            occ = 2'(q.size());
            chk("out_valid", {127'b0, out_valid}, {127'b0, v});
            chk("in_ready",  {127'b0, in_ready},  {127'b0, q.size() < 2});
            chk("occupancy", {126'b0, occupancy}, {126'b0, occ});
            chk("out_ops",   out_ops, main_hold.ops);
            chk("out_rd",    {124'b0, out_rd}, {124'b0, main_hold.rd});
            chk("out_ctrl",  {119'b0, out_ctrl}, {119'b0, v ? main_hold.ctrl : 9'h0});
            chk("n_valid",   {127'b0, out_valid2}, {127'b0, v});
            chk("n_ready",   {127'b0, in_ready2},  {127'b0, q.size() < 2});
            chk("n_occ",     {126'b0, occupancy2}, {126'b0, occ});
            chk("n_ops",     {96'b0, out_ops2}, {96'b0, main_hold.ops[47:32], main_hold.ops[15:0]});
            chk("n_rd",      {124'b0, out_rd2}, {124'b0, main_hold.rd});
            chk("n_ctrl",    {119'b0, out_ctrl2}, {119'b0, v ? main_hold.ctrl : 9'h0});
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic v, input logic [31:0] w0, input logic [3:0] rd, input logic [8:0] ctrl);
        in_valid = v;
        in_ops   = {32'h0, 32'h0, 32'h0, w0};
        in_rd    = rd;
        in_ctrl  = ctrl;
    endtask

    initial begin
        reset = 1'b1;
        repeat (2) cyc();
        reset = 1'b0;
        chk("rst_valid", {127'b0, out_valid}, 128'd0);
        chk("rst_ops",   out_ops, 128'd0);
        chk("rst_rd",    {124'b0, out_rd}, 128'd0);
        chk("rst_ready", {127'b0, in_ready}, 128'd1);
        chk("rst_occ",   {126'b0, occupancy}, 128'd0);
        drive(1'b0, 32'h0, 4'h0, 9'h1FF);
        cyc();
        chk("idle_ctrl", {119'b0, out_ctrl}, 128'd0);

        // Streaming at full rate
        out_ready = 1'b1;
        drive(1'b1, 32'h11, 4'h1, 9'h011); cyc();
        chk("s1_valid", {127'b0, out_valid}, 128'd1);
        chk("s1_ops",   {96'b0, out_ops[31:0]}, 128'h11);
        chk("s1_occ",   {126'b0, occupancy}, 128'd1);
        drive(1'b1, 32'h22, 4'h2, 9'h022); cyc();
        chk("s2_ops",   {96'b0, out_ops[31:0]}, 128'h22);
        chk("s2_valid", {127'b0, out_valid}, 128'd1);
        drive(1'b1, 32'h33, 4'h3, 9'h033); cyc();
        chk("s3_ops",   {96'b0, out_ops[31:0]}, 128'h33);
        chk("s3_occ",   {126'b0, occupancy}, 128'd1);
        drive(1'b1, 32'hBEEF, 4'h4, 9'h044); cyc();
        chk("n_beef",   {112'b0, out_ops2[15:0]}, 128'hBEEF);
        drive(1'b0, 32'h0, 4'h0, 9'h0); cyc();
        chk("s_drain",  {127'b0, out_valid}, 128'd0);

        // Back-pressure: A then B fill both entries
        out_ready = 1'b0;
        drive(1'b1, 32'hA, 4'hA, 9'h0AA); cyc();
        drive(1'b1, 32'hB, 4'hB, 9'h0BB); cyc();
        chk("bp_occ",   {126'b0, occupancy}, 128'd2);
        chk("bp_ready", {127'b0, in_ready}, 128'd0);
        chk("bp_ops",   {96'b0, out_ops[31:0]}, 128'hA);
        chk("bp_n_occ", {126'b0, occupancy2}, 128'd2);
        drive(1'b0, 32'h0, 4'h0, 9'h0);
        out_ready = 1'b1; cyc();
        chk("bp_b_ops", {96'b0, out_ops[31:0]}, 128'hB);
        chk("bp_ready1", {127'b0, in_ready}, 128'd1);
        cyc();
        chk("bp_empty", {126'b0, occupancy}, 128'd0);

        // Flush while full with C offered
        out_ready = 1'b0;
        drive(1'b1, 32'hA1, 4'h1, 9'h1A1); cyc();
        drive(1'b1, 32'hB2, 4'h2, 9'h1B2); cyc();
        drive(1'b1, 32'hC3, 4'h3, 9'h1C3);
        flush = 1'b1; cyc();
        flush = 1'b0;
        drive(1'b0, 32'h0, 4'h0, 9'h0);
        chk("fl_valid", {127'b0, out_valid}, 128'd0);
        chk("fl_ctrl",  {119'b0, out_ctrl}, 128'd0);
        chk("fl_occ",   {126'b0, occupancy}, 128'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("fl_noc", {127'b0, out_valid}, 128'd0);
        end

        // Reset mid-stream
        out_ready = 1'b0;
        drive(1'b1, 32'h77, 4'h7, 9'h077); cyc();
        drive(1'b1, 32'h78, 4'h7, 9'h078); cyc();
        chk("rm_occ", {126'b0, occupancy}, 128'd2);
        reset = 1'b1; cyc();
        reset = 1'b0;
        drive(1'b0, 32'h0, 4'h0, 9'h0);
        chk("rm_rd",   {124'b0, out_rd}, 128'd0);
        chk("rm_ops",  out_ops, 128'd0);
        chk("rm_occ0", {126'b0, occupancy}, 128'd0);

        // Randomized traffic, checked cycle by cycle against the model
        for (int i = 0; i < 3000; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            reset     = ($urandom_range(0, 199) == 0);
            in_ops    = {$urandom, $urandom, $urandom, $urandom};
            in_rd     = 4'($urandom);
            in_ctrl   = 9'($urandom);
            cyc();
        end
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0;
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_pipe_skid_reg
`default_nettype wire
